// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

    localparam int BAUD       = 9600;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rxd_if.sv
// rtl/uart_rxd_if.sv - byte handoff bus between the UART receiver and its consumer
interface uart_rxd_if #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS
);

    logic                 ack;
    logic [DATA_BITS-1:0] data;
    logic                 rdy;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        input  ack,
        output data, rdy, frame_err, overrun, busy
    );

    modport slave (
        output ack,
        input  data, rdy, frame_err, overrun, busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer, resets to all ones (idle line level)
module uart_rx_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rxd.sv
// rtl/uart_rxd.sv - 16x oversampling 8N1 UART receiver with a 1-entry holding register
module uart_rxd
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int DATA_BITS  = uart_pkg::DATA_BITS
) (
    input  logic         clk_153600Hz,
    input  logic         rst,
    input  logic         rxd,
    uart_rxd_if.master   bus
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rxd_s;
    rx_state_t            state;
    logic [SW-1:0]        sample_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] data_r;
    logic                 rdy_r;
    logic                 frame_err_r;
    logic                 overrun_r;

    uart_rx_sync #(.WIDTH(1)) u_sync (
        .clk (clk_153600Hz),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    always_ff @(posedge clk_153600Hz) begin
        if (rst) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            data_r      <= '0;
            rdy_r       <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            if (bus.ack && rdy_r) begin
                rdy_r     <= 1'b0;
                overrun_r <= 1'b0;
            end
            case (state)
                IDLE: begin
                    sample_cnt <= '0;
                    bit_cnt    <= '0;
                    if (!rxd_s)
                        state <= START;
                end
                START: begin
                    if (sample_cnt == HALF_LAST) begin
                        sample_cnt <= '0;
                        state      <= rxd_s ? IDLE : DATA;
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (sample_cnt == FULL_LAST) begin
                        sample_cnt <= '0;
                        shift      <= {rxd_s, shift[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (sample_cnt == FULL_LAST) begin
                        sample_cnt <= '0;
                        if (rxd_s) begin
                            // A same-cycle ack consumed the old byte, so only an unacked byte counts as overrun.
                            data_r <= shift;
                            rdy_r  <= 1'b1;
                            if (rdy_r && !bus.ack)
                                overrun_r <= 1'b1;
                            state <= IDLE;
                        end else begin
                            frame_err_r <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxd_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data      = data_r;
    assign bus.rdy       = rdy_r;
    assign bus.frame_err = frame_err_r;
    assign bus.overrun   = overrun_r;
    assign bus.busy      = (state != IDLE);

endmodule
